// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = DIGIT_W'(5);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4,
    ST_EXPIRED = 3'd5
  } state_e;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 register: load preset, increment with 59->00 wrap,
// decrement with borrow out on 00->59.
module bcd_mod60
  import timer_pkg::*;
#(
  parameter int unsigned PRESET = 0
) (
  input  logic               clk_sel,
  input  logic               rst,
  input  logic               load,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               is_zero_c,
  output logic               borrow_c
);

  localparam logic [DIGIT_W-1:0] PRE_TENS = DIGIT_W'(PRESET / 10);
  localparam logic [DIGIT_W-1:0] PRE_ONES = DIGIT_W'(PRESET % 10);

  logic [DIGIT_W-1:0] tens_d;
  logic [DIGIT_W-1:0] ones_d;

  assign is_zero_c = (tens == '0) && (ones == '0);
  assign borrow_c  = dec && !load && !inc && is_zero_c;

  // Next value: load beats inc beats dec.
  always_comb begin
    tens_d = tens;
    ones_d = ones;
    if (load) begin
      tens_d = PRE_TENS;
      ones_d = PRE_ONES;
    end else if (inc) begin
      if (ones == BCD_MAX_ONES) begin
        ones_d = '0;
        tens_d = (tens == BCD_MAX_TENS) ? '0 : tens + DIGIT_W'(1);
      end else begin
        ones_d = ones + DIGIT_W'(1);
      end
    end else if (dec) begin
      if (ones == '0) begin
        ones_d = BCD_MAX_ONES;
        tens_d = (tens == '0) ? BCD_MAX_TENS : tens - DIGIT_W'(1);
      end else begin
        ones_d = ones - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      tens <= PRE_TENS;
      ones <= PRE_ONES;
    end else begin
      tens <= tens_d;
      ones <= ones_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: adjust-mode setting, run/hold, sticky expiry at 00:00.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned PRESET_MIN = 0,
  parameter int unsigned PRESET_SEC = 0
) (
  input  logic               clk_sel,
  input  logic               rst,
  input  logic               clr,
  input  logic               run_en,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic               blink_min,
  output logic               blink_sec,
  output logic               running,
  output logic               expired
);

  state_e state_q;
  state_e state_d;
  state_e set_tgt;

  logic clr_load;
  logic sec_inc;
  logic min_inc;
  logic run_dec;
  logic sec_zero;
  logic min_zero;
  logic sec_borrow;
  logic min_borrow_unused;
  logic time_zero;
  logic time_one;

  bcd_mod60 #(.PRESET(PRESET_SEC)) u_sec (
    .clk_sel   (clk_sel),
    .rst       (rst),
    .load      (clr_load),
    .inc       (sec_inc),
    .dec       (run_dec),
    .tens      (digit1),
    .ones      (digit0),
    .is_zero_c (sec_zero),
    .borrow_c  (sec_borrow)
  );

  // Minutes only step down when seconds wrap 00 -> 59.
  bcd_mod60 #(.PRESET(PRESET_MIN)) u_min (
    .clk_sel   (clk_sel),
    .rst       (rst),
    .load      (clr_load),
    .inc       (min_inc),
    .dec       (sec_borrow),
    .tens      (digit3),
    .ones      (digit2),
    .is_zero_c (min_zero),
    .borrow_c  (min_borrow_unused)
  );

  assign time_zero = min_zero && sec_zero;
  assign time_one  = min_zero && (digit1 == '0) && (digit0 == DIGIT_W'(1));

  // Next state and datapath controls; priority clr > adj > run_en.
  always_comb begin
    state_d  = state_q;
    clr_load = 1'b0;
    sec_inc  = 1'b0;
    min_inc  = 1'b0;
    run_dec  = 1'b0;
    set_tgt  = sel ? ST_SET_SEC : ST_SET_MIN;
    if (clr) begin
      clr_load = 1'b1;
      state_d  = ST_IDLE;
    end else if (adj) begin
      state_d = set_tgt;
      if (state_q == set_tgt) begin
        sec_inc = sel;
        min_inc = !sel;
      end
    end else begin
      unique case (state_q)
        ST_SET_MIN, ST_SET_SEC: state_d = ST_IDLE;
        ST_IDLE: if (run_en && !time_zero) state_d = ST_RUN;
        ST_HOLD: if (run_en) state_d = time_zero ? ST_EXPIRED : ST_RUN;
        ST_RUN: begin
          if (!run_en) begin
            state_d = ST_HOLD;
          end else if (time_zero) begin
            state_d = ST_EXPIRED;
          end else begin
            run_dec = 1'b1;
            if (time_one) state_d = ST_EXPIRED;
          end
        end
        ST_EXPIRED: state_d = ST_EXPIRED;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state_q   <= state_d;
      blink_min <= (state_d == ST_SET_MIN);
      blink_sec <= (state_d == ST_SET_SEC);
      running   <= (state_d == ST_RUN);
      expired   <= (state_d == ST_EXPIRED);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed MM:SS expectations.
module tb_countdown_timer;

  logic       clk_sel = 1'b0;
  logic       rst     = 1'b1;
  logic       clr     = 1'b0;
  logic       run_en  = 1'b0;
  logic       adj     = 1'b0;
  logic       sel     = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       blink_min, blink_sec, running, expired;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer #(.PRESET_MIN(0), .PRESET_SEC(0)) dut (
    .clk_sel   (clk_sel),
    .rst       (rst),
    .clr       (clr),
    .run_en    (run_en),
    .adj       (adj),
    .sel       (sel),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .blink_min (blink_min),
    .blink_sec (blink_sec),
    .running   (running),
    .expired   (expired)
  );

  always #5 clk_sel = ~clk_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Time as 16'hMMSS, flags as {blink_min, blink_sec, running, expired}.
  task automatic check_st(input string tag, input logic [15:0] exp_time, input logic [3:0] exp_flags);
    check({tag, ".time"}, 32'({digit3, digit2, digit1, digit0}), 32'(exp_time));
    check({tag, ".flags"}, 32'({blink_min, blink_sec, running, expired}), 32'(exp_flags));
  endtask

  task automatic tick();
    @(posedge clk_sel);
    #1;
  endtask

  // Clear to 00:00, then set MM:SS via adjust mode, ending in IDLE.
  task automatic load_time(input int m, input int s);
    run_en = 1'b0;
    clr = 1'b1; adj = 1'b0; tick();
    clr = 1'b0; adj = 1'b1; sel = 1'b0; tick();
    repeat (m) tick();
    sel = 1'b1; tick();
    repeat (s) tick();
    adj = 1'b0; tick();
  endtask

  initial begin
    #12;
    check_st("reset", 16'h0000, 4'b0000);
    rst = 1'b0;

    // 1: five SET_SEC edges, entry edge not counted
    adj = 1'b1; sel = 1'b1; tick();
    check_st("t1.entry", 16'h0000, 4'b0100);
    repeat (4) tick();
    check_st("t1.set", 16'h0004, 4'b0100);
    adj = 1'b0; tick();
    check_st("t1.idle", 16'h0004, 4'b0000);

    // 2: seconds wrap 59 -> 00, no carry into minutes
    load_time(0, 58);
    check_st("t2.loaded", 16'h0058, 4'b0000);
    adj = 1'b1; sel = 1'b1; tick();
    check_st("t2.entry", 16'h0058, 4'b0100);
    tick(); check_st("t2.s59", 16'h0059, 4'b0100);
    tick(); check_st("t2.s00", 16'h0000, 4'b0100);
    tick(); check_st("t2.s01", 16'h0001, 4'b0100);

    // minutes wrap 59 -> 00, seconds hold
    load_time(59, 7);
    adj = 1'b1; sel = 1'b0; tick();
    check_st("tm.entry", 16'h5907, 4'b1000);
    tick(); check_st("tm.wrap", 16'h0007, 4'b1000);

    // 3: run from 01:00
    load_time(1, 0);
    run_en = 1'b1; tick();
    check_st("t3.entry", 16'h0100, 4'b0010);
    tick(); check_st("t3.0059", 16'h0059, 4'b0010);
    tick(); check_st("t3.0058", 16'h0058, 4'b0010);

    // 4: expire on the edge that reaches 00:00, then stick
    load_time(0, 2);
    run_en = 1'b1; tick();
    check_st("t4.entry", 16'h0002, 4'b0010);
    tick(); check_st("t4.0001", 16'h0001, 4'b0010);
    tick(); check_st("t4.expire", 16'h0000, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick(); check_st("t4.stick", 16'h0000, 4'b0001);
    end

    // 5: pause and resume at 10:00, borrow across both fields
    load_time(10, 0);
    run_en = 1'b1; tick();
    check_st("t5.run", 16'h1000, 4'b0010);
    run_en = 1'b0; tick();
    check_st("t5.hold", 16'h1000, 4'b0000);
    run_en = 1'b1; tick();
    check_st("t5.resume", 16'h1000, 4'b0010);
    tick(); check_st("t5.0959", 16'h0959, 4'b0010);

    // 6: clr beats adj in RUN; zero value in IDLE does not start
    clr = 1'b1; adj = 1'b1; tick();
    check_st("t6.clr", 16'h0000, 4'b0000);
    clr = 1'b0; adj = 1'b0; tick();
    check_st("t6.idle0", 16'h0000, 4'b0000);

    // async reset mid-run
    load_time(0, 30);
    run_en = 1'b1; tick(); tick();
    check_st("t6.run", 16'h0029, 4'b0010);
    #2 rst = 1'b1;
    #1 check_st("t6.rst", 16'h0000, 4'b0000);
    #2 rst = 1'b0;
    run_en = 1'b0;
    tick();
    check_st("t6.post", 16'h0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
